// File: rtl/mac_pipe_pkg.sv
// mac_pipe_pkg: shared types and default widths for the multiply-add /
// multiply-accumulate pipeline.
//   mac_mode_t            - MAC_ADD (A*B+C) or MAC_ACC (running sum of A*B)
//   MAC_WIDTH             - default operand width
//   MAC_ACC_WIDTH         - default result/accumulator width
//   MAC_CNT_WIDTH         - default term-counter width
//   macWidthsLegal()      - true when an accumulator can hold any A*B+C
//   MAC_DEFAULT_WIDTHS_OK - legality of the default widths
package mac_pipe_pkg;

    typedef enum logic {
        MAC_ADD = 1'b0,
        MAC_ACC = 1'b1
    } mac_mode_t;

    localparam int unsigned MAC_WIDTH     = 8;
    localparam int unsigned MAC_ACC_WIDTH = 2 * MAC_WIDTH + 4;
    localparam int unsigned MAC_CNT_WIDTH = 8;

    // One extra bit over the full product is what keeps A*B+C overflow-free.
    function automatic bit macWidthsLegal(input int unsigned width, input int unsigned accWidth);
        return (width > 0) && (accWidth >= 2 * width + 1);
    endfunction

    localparam bit MAC_DEFAULT_WIDTHS_OK = macWidthsLegal(MAC_WIDTH, MAC_ACC_WIDTH);

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational extend-add-clamp used by the final pipeline stage.
// Both operands are already ACC_WIDTH wide; the sum is formed one bit wider
// and clamped back into the signed or unsigned ACC_WIDTH range.
//   SIGNED    - 0: unsigned operands/range, 1: two's-complement
//   ACC_WIDTH - operand and result width
//   addend    in  ACC_WIDTH  running sum or extended C
//   product   in  ACC_WIDTH  extended A*B product
//   sum       out ACC_WIDTH  clamped sum
//   ovf       out 1          clamping took place
module mac_sat_add #(
    parameter int unsigned SIGNED    = 0,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic [ACC_WIDTH-1:0] addend,
    input  logic [ACC_WIDTH-1:0] product,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    localparam logic [ACC_WIDTH-1:0] SIGNED_MAX   = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SIGNED_MIN   = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UNSIGNED_MAX = '1;

    logic [ACC_WIDTH:0] wide;

    always_comb begin
        wide = {IS_SIGNED & addend[ACC_WIDTH-1], addend}
             + {IS_SIGNED & product[ACC_WIDTH-1], product};
        sum  = wide[ACC_WIDTH-1:0];
        ovf  = 1'b0;
        if (IS_SIGNED) begin
            // Top two bits disagree: result left the signed range; the top
            // bit carries the true sign and picks the rail.
            if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                ovf = 1'b1;
                sum = wide[ACC_WIDTH] ? SIGNED_MIN : SIGNED_MAX;
            end
        end else if (wide[ACC_WIDTH]) begin
            // Unsigned operands never go below zero, only the top rail exists.
            ovf = 1'b1;
            sum = UNSIGNED_MAX;
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined multiply-add / multiply-accumulate unit.
// One operand triple per clock, result exactly three clocks later.
//   clock     in  1          rising-edge clock
//   reset_n   in  1          asynchronous active-low reset
//   in_valid  in  1          operand triple valid
//   A, B, C   in  WIDTH      operands
//   mode      in  1          0: A*B+C, 1: accumulate A*B
//   clear     in  1          mode 1: start a new sum seeded with C
//   out_valid out 1          one-cycle pulse per accepted input
//   DATA_OUT  out ACC_WIDTH  result / accumulator
//   ovf       out 1          saturation on this result (qualified by out_valid)
//   terms     out CNT_WIDTH  products in the current sum
//   check1    out ACC_WIDTH  stage-2 product, extended (debug)
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = MAC_WIDTH,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4,
    parameter int unsigned CNT_WIDTH = MAC_CNT_WIDTH,
    parameter int unsigned SIGNED    = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    input  logic                 mode,
    input  logic                 clear,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] DATA_OUT,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] terms,
    output logic [ACC_WIDTH-1:0] check1
);

    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam int unsigned PROD_WIDTH = 2 * WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    if (!MAC_DEFAULT_WIDTHS_OK || !macWidthsLegal(WIDTH, ACC_WIDTH)) begin : gWidthCheck
        $error("mac_pipe: ACC_WIDTH must be at least 2*WIDTH+1");
    end

    // ---------------- Stage 1: operand capture ----------------
    logic [WIDTH-1:0] a1, b1, c1;
    mac_mode_t        mode1;
    logic             clear1;
    logic             valid1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a1     <= '0;
            b1     <= '0;
            c1     <= '0;
            mode1  <= MAC_ADD;
            clear1 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= in_valid;
            if (in_valid) begin
                a1     <= A;
                b1     <= B;
                c1     <= C;
                mode1  <= mac_mode_t'(mode);
                clear1 <= clear;
            end
        end
    end

    // ---------------- Stage 2: multiply ----------------
    // Extending both operands to the full product width first makes one
    // unsigned multiplier give the right low 2*WIDTH bits in either mode.
    logic [PROD_WIDTH-1:0] a1Ext, b1Ext, product;

    assign a1Ext   = {{WIDTH{IS_SIGNED & a1[WIDTH-1]}}, a1};
    assign b1Ext   = {{WIDTH{IS_SIGNED & b1[WIDTH-1]}}, b1};
    assign product = a1Ext * b1Ext;

    logic [PROD_WIDTH-1:0] prod2;
    logic [WIDTH-1:0]      c2;
    mac_mode_t             mode2;
    logic                  clear2;
    logic                  valid2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod2  <= '0;
            c2     <= '0;
            mode2  <= MAC_ADD;
            clear2 <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            prod2  <= product;
            c2     <= c1;
            mode2  <= mode1;
            clear2 <= clear1;
            valid2 <= valid1;
        end
    end

    // ---------------- Stage 3: add / accumulate ----------------
    logic [ACC_WIDTH-1:0] prodExt, cExt, addend, satSum;
    logic                 satOvf;

    logic [ACC_WIDTH-1:0] accQ, accD;
    logic                 ovfQ, ovfD;
    logic [CNT_WIDTH-1:0] termsQ, termsD;
    logic                 valid3;

    assign prodExt = {{(ACC_WIDTH - PROD_WIDTH){IS_SIGNED & prod2[PROD_WIDTH-1]}}, prod2};
    assign cExt    = {{(ACC_WIDTH - WIDTH){IS_SIGNED & c2[WIDTH-1]}}, c2};

    // The stage-3 register is the feedback path, so back-to-back
    // accumulation needs no forwarding.
    assign addend = ((mode2 == MAC_ADD) || clear2) ? cExt : accQ;

    mac_sat_add #(
        .SIGNED    (SIGNED),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .addend  (addend),
        .product (prodExt),
        .sum     (satSum),
        .ovf     (satOvf)
    );

    always_comb begin
        accD   = accQ;
        ovfD   = ovfQ;
        termsD = termsQ;
        if (valid2) begin
            accD = satSum;
            if (mode2 == MAC_ADD) begin
                ovfD   = 1'b0;
                termsD = CNT_ONE;
            end else begin
                ovfD = satOvf;
                if (clear2) begin
                    termsD = CNT_ONE;
                end else if (!(&termsQ)) begin
                    termsD = termsQ + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            accQ   <= '0;
            ovfQ   <= 1'b0;
            termsQ <= '0;
            valid3 <= 1'b0;
        end else begin
            accQ   <= accD;
            ovfQ   <= ovfD;
            termsQ <= termsD;
            valid3 <= valid2;
        end
    end

    assign out_valid = valid3;
    assign DATA_OUT  = accQ;
    assign ovf       = ovfQ;
    assign terms     = termsQ;
    assign check1    = prodExt;

endmodule
